// File: rtl/ro_freq_meter_pkg.sv
// Shared types and default widths for the ring-oscillator frequency meter.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } meter_state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int GATE_W_DEF      = 16;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic logic is_busy(meter_state_e s);
    return (s == ARM) || (s == GATE);
  endfunction

endpackage

// File: rtl/ro_freq_meter_if.sv
// Control / result bus of the frequency meter; master is the controller, slave the meter.
interface ro_freq_meter_if #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
);
  logic              start;
  logic [GATE_W-1:0] gate_cycles;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              rd_shift;
  logic              rd_data;

  modport master (
    output start, gate_cycles, rd_shift,
    input  busy, done, count, overflow, rd_data
  );

  modport slave (
    input  start, gate_cycles, rd_shift,
    output busy, done, count, overflow, rd_data
  );
endinterface

// File: rtl/ro_sync_edge.sv
// Synchronizes the asynchronous oscillator input and flags its rising edges.
module ro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic rearm,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= synced;
    end
  end

  // while re-arming the history is realigned to the synced level, so no edge is reported
  assign rise = synced & ~hist_q & ~rearm;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated rising-edge counter for a divided ring oscillator with parallel/serial readout.
// RO_FREQ_METER_CONTINUOUS_EN: re-arm after every result instead of returning to IDLE.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int GATE_W      = GATE_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           osc_in,
  ro_freq_meter_if.slave bus
);
  meter_state_e      state_q, state_d;
  logic [GATE_W-1:0] gate_len_q;
  logic [GATE_W-1:0] gate_ctr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  res_q;
  logic              ovf_q;
  logic              rise;
  logic              cnt_sat;

  ro_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (osc_in),
    .rearm    (state_q == ARM),
    .rise     (rise)
  );

  assign cnt_sat = &cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = ARM;
      ARM:  state_d = (gate_len_q == '0) ? DONE : GATE;
      GATE: if (gate_ctr_q == GATE_W'(1)) state_d = DONE;
`ifdef RO_FREQ_METER_CONTINUOUS_EN
      DONE: state_d = ARM;
`else
      DONE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_len_q <= '0;
      gate_ctr_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.start) begin
          gate_len_q <= bus.gate_cycles;
          cnt_q      <= '0;
          ovf_q      <= 1'b0;
        end
        ARM: begin
          gate_ctr_q <= gate_len_q;
          cnt_q      <= '0;
`ifdef RO_FREQ_METER_CONTINUOUS_EN
          ovf_q      <= 1'b0;
`endif
        end
        GATE: begin
          gate_ctr_q <= gate_ctr_q - GATE_W'(1);
          if (rise) begin
            if (cnt_sat) ovf_q <= 1'b1;
            else         cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // result register: the load in DONE takes priority over a pending shift
  always_ff @(posedge clk) begin
    if (rst)                  res_q <= '0;
    else if (state_q == DONE) res_q <= cnt_q;
    else if (bus.rd_shift)    res_q <= {res_q[CNT_W-2:0], 1'b0};
  end

  // the result is already visible in the DONE cycle, before res_q captures it
  assign bus.count    = (state_q == DONE) ? cnt_q : res_q;
  assign bus.rd_data  = bus.count[CNT_W-1];
  assign bus.done     = (state_q == DONE);
  assign bus.busy     = is_busy(state_q);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench: a 16-bit and a 4-bit meter share clk, rst and osc_in.
module tb_ro_freq_meter;
  logic clk = 1'b0;
  logic rst;
  logic osc;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   osc_mode = 0;

  always #5 clk = ~clk;

  ro_freq_meter_if #(.CNT_W(16), .GATE_W(16)) b16 ();
  ro_freq_meter_if #(.CNT_W(4),  .GATE_W(16)) b4 ();

  ro_freq_meter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .osc_in(osc), .bus(b16));
  ro_freq_meter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .osc_in(osc), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // n = negedges since start was raised; mode 1: rise at n=3, period 8; mode 2: high on odd n
  task automatic drive_osc(input int n);
    case (osc_mode)
      1: osc = (n >= 3) && (((n - 3) % 8) < 4);
      2: osc = (n % 2) == 1;
      default: ;
    endcase
  endtask

  task automatic start_both(input int g);
    @(negedge clk);
    b16.start = 1'b1;        b4.start = 1'b1;
    b16.gate_cycles = 16'(g); b4.gate_cycles = 16'(g);
  endtask

  task automatic run_until_done(input int limit, output int n_done);
    n_done = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) begin b16.start = 1'b0; b4.start = 1'b0; end
      if (b16.done) begin n_done = n; break; end
      drive_osc(n);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int nd;
    int ndone;
    rst = 1'b1; osc = 1'b0;
    b16.start = 0; b4.start = 0; b16.rd_shift = 0; b4.rd_shift = 0;
    b16.gate_cycles = 0; b4.gate_cycles = 0;
    idle(3);
    chk("rst_busy", b16.busy, 0);
    chk("rst_done", b16.done, 0);
    chk("rst_count", b16.count, 0);
    chk("rst_ovf", b16.overflow, 0);
    chk("rst_rd_data", b16.rd_data, 0);
    rst = 1'b0;
    idle(2);

`ifdef RO_FREQ_METER_CONTINUOUS_EN
    osc_mode = 2;
    start_both(6);
    ndone = 0;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (n == 1) begin b16.start = 1'b0; b4.start = 1'b0; end
      if (b16.done) begin
        ndone++;
        chk("cont_done_time", n, 8 * ndone);
        chk("cont_count", b16.count, 3);
      end
      if (n == 11) chk("cont_shifted", b16.count, 6);
      b16.rd_shift = (n == 10);
      drive_osc(n);
    end
    chk("cont_ndone", ndone, 3);
`else
    // period-8 input, first rise 3 cycles after start: 8 edges in 64 gate cycles
    osc_mode = 1;
    start_both(64);
    run_until_done(200, nd);
    chk("cnt_done_time", nd, 66);
    chk("cnt_count16", b16.count, 8);
    chk("cnt_ovf16", b16.overflow, 0);
    chk("cnt_count4", b4.count, 8);
    @(negedge clk);
    chk("cnt_done_pulse", b16.done, 0);
    chk("cnt_busy_after", b16.busy, 0);
    chk("cnt_hold", b16.count, 8);

    // reset in the middle of GATE
    osc = 1'b0;
    start_both(50);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin b16.start = 1'b0; b4.start = 1'b0; end
      drive_osc(n);
    end
    chk("rstm_busy_pre", b16.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_busy", b16.busy, 0);
    chk("rstm_count", b16.count, 0);
    chk("rstm_done", b16.done, 0);
    ndone = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (b16.done) ndone++;
    end
    chk("rstm_no_done", ndone, 0);

    // zero gate length
    osc_mode = 0; osc = 1'b0;
    start_both(0);
    run_until_done(20, nd);
    chk("zero_done_time", nd, 2);
    chk("zero_count", b16.count, 0);

    // level already high before start is not an edge
    osc = 1'b1;
    idle(5);
    start_both(100);
    run_until_done(200, nd);
    chk("static_done_time", nd, 102);
    chk("static_count", b16.count, 0);

    // second start while busy is dropped
    osc = 1'b0;
    idle(4);
    start_both(10);
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (b16.done) begin
        ndone++;
        chk("busy_done_time", n, 12);
      end
      b16.start = (n == 4); b4.start = (n == 4);
    end
    chk("busy_ndone", ndone, 1);

    // period-2 input: 32 edges; 4-bit counter saturates
    osc_mode = 2; osc = 1'b0;
    idle(4);
    start_both(64);
    run_until_done(200, nd);
    chk("sat_done_time", nd, 66);
    chk("sat_count16", b16.count, 32'h20);
    chk("sat_ovf16", b16.overflow, 0);
    chk("sat_count4", b4.count, 15);
    chk("sat_ovf4", b4.overflow, 1);
    osc_mode = 0;
    @(negedge clk);

    // serial readout MSB first
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rd16_bit%0d", i), b16.rd_data, (32'h0020 >> (15 - i)) & 1);
      chk($sformatf("rd4_bit%0d", i), b4.rd_data, (i < 4) ? 1 : 0);
      b16.rd_shift = 1'b1; b4.rd_shift = 1'b1;
      @(negedge clk);
      b16.rd_shift = 1'b0; b4.rd_shift = 1'b0;
    end
    chk("rd16_final", b16.count, 0);
    chk("rd4_final", b4.count, 0);
    chk("rd4_ovf_sticky", b4.overflow, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
